// File: rtl/hamming_error_monitor.sv
// Hamming(7,4) error monitor: snapshots a protected counter, scans one nibble per
// cycle, queues classified error events and keeps saturating error statistics.
module hamming_error_monitor #(
  parameter  int unsigned WIDTH       = 8,
  parameter  int unsigned FIFO_DEPTH  = 4,
  parameter  int unsigned CNT_W       = 8,
  localparam int unsigned BLOCKS      = WIDTH / 4,
  localparam int unsigned PARITY_BITS = BLOCKS * 3,
  localparam int unsigned IDX_W       = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   check_req,
  input  logic [WIDTH-1:0]       counter,
  input  logic [PARITY_BITS-1:0] parity_stored,
  output logic                   chk_busy,
  output logic                   check_done,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDX_W-1:0]       evt_block,
  output logic [1:0]             evt_type,
  output logic [2:0]             evt_syndrome,
  output logic [1:0]             evt_bitpos,
  output logic [CNT_W-1:0]       data_err_cnt,
  output logic [CNT_W-1:0]       parity_err_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);
  localparam logic [1:0] TYPE_DATA   = 2'b01;
  localparam logic [1:0] TYPE_PARITY = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] blk;
    logic [1:0]       typ;
    logic [2:0]       syn;
    logic [1:0]       pos;
  } evt_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [WIDTH-1:0]       r_snap_cnt;
  logic [PARITY_BITS-1:0] r_snap_par;
  logic                   r_busy;
  logic                   r_done;

  evt_t                   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [OCC_W-1:0]       r_count;
  logic [CNT_W-1:0]       r_data_cnt;
  logic [CNT_W-1:0]       r_par_cnt;
  logic [CNT_W-1:0]       r_drop_cnt;
  logic                   r_ovf;

  logic [3:0]             w_nibs [BLOCKS];
  logic [2:0]             w_pars [BLOCKS];
  logic [3:0]             w_nib;
  logic [2:0]             w_par;
  logic [2:0]             w_syn;
  logic [1:0]             w_type;
  logic [1:0]             w_pos;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_write;
  logic                   w_drop;
  evt_t                   w_evt;

  // Split the snapshot into per-block views so the scan index selects one nibble.
  for (genvar g = 0; g < BLOCKS; g++) begin : g_blk
    assign w_nibs[g] = r_snap_cnt[g*4 +: 4];
    assign w_pars[g] = r_snap_par[g*3 +: 3];
  end

  always_comb begin
    w_nib    = w_nibs[r_idx];
    w_par    = w_pars[r_idx];
    w_syn[2] = w_par[2] ^ w_nib[0] ^ w_nib[2] ^ w_nib[3];
    w_syn[1] = w_par[1] ^ w_nib[0] ^ w_nib[1] ^ w_nib[3];
    w_syn[0] = w_par[0] ^ w_nib[0] ^ w_nib[1] ^ w_nib[2];
    w_type   = 2'b00;
    w_pos    = 2'b00;
    // Single-bit syndromes point at a parity bit; the rest name the flipped data bit.
    case (w_syn)
      3'b001: begin w_type = TYPE_PARITY; w_pos = 2'd0; end
      3'b010: begin w_type = TYPE_PARITY; w_pos = 2'd1; end
      3'b100: begin w_type = TYPE_PARITY; w_pos = 2'd2; end
      3'b111: begin w_type = TYPE_DATA;   w_pos = 2'd0; end
      3'b011: begin w_type = TYPE_DATA;   w_pos = 2'd1; end
      3'b101: begin w_type = TYPE_DATA;   w_pos = 2'd2; end
      3'b110: begin w_type = TYPE_DATA;   w_pos = 2'd3; end
      default: begin w_type = 2'b00;      w_pos = 2'd0; end
    endcase
    w_evt   = '{blk: r_idx, typ: w_type, syn: w_syn, pos: w_pos};
    w_push  = (r_state == S_SCAN) && (w_syn != 3'b000);
    w_pop   = (r_count != '0) && evt_ready;
    w_full  = (r_count == OCC_W'(FIFO_DEPTH));
    w_write = w_push && (!w_full || w_pop);
    w_drop  = w_push && w_full && !w_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_snap_cnt <= '0;
      r_snap_par <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (check_req) begin
            r_snap_cnt <= counter;
            r_snap_par <= parity_stored;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Event FIFO and statistics; a push into a full FIFO survives only if the head pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem      <= '{default: '0};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_cnt <= '0;
      r_par_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr] <= w_evt;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + OCC_W'(1);
      end else if (!w_write && w_pop) begin
        r_count <= r_count - OCC_W'(1);
      end
      if (w_push && (w_type == TYPE_DATA) && (r_data_cnt != '1)) begin
        r_data_cnt <= r_data_cnt + CNT_W'(1);
      end
      if (w_push && (w_type == TYPE_PARITY) && (r_par_cnt != '1)) begin
        r_par_cnt <= r_par_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign chk_busy       = r_busy;
  assign check_done     = r_done;
  assign evt_valid      = (r_count != '0);
  assign evt_block      = r_mem[r_rd_ptr].blk;
  assign evt_type       = r_mem[r_rd_ptr].typ;
  assign evt_syndrome   = r_mem[r_rd_ptr].syn;
  assign evt_bitpos     = r_mem[r_rd_ptr].pos;
  assign data_err_cnt   = r_data_cnt;
  assign parity_err_cnt = r_par_cnt;
  assign drop_cnt       = r_drop_cnt;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_hamming_error_monitor.sv
// Self-checking bench for hamming_error_monitor: event-queue reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_hamming_error_monitor;

  localparam int BLOCKS = 2;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       check_req = 1'b0;
  logic [7:0] counter = '0;
  logic [5:0] parity_stored = '0;
  logic       evt_ready = 1'b0;
  logic       chk_busy, check_done, evt_valid, overflow;
  logic [0:0] evt_block;
  logic [1:0] evt_type, evt_bitpos;
  logic [2:0] evt_syndrome;
  logic [7:0] data_err_cnt, parity_err_cnt, drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int last_lat;

  hamming_error_monitor dut (
    .clk(clk), .rst(rst), .check_req(check_req), .counter(counter),
    .parity_stored(parity_stored), .chk_busy(chk_busy), .check_done(check_done),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_block(evt_block),
    .evt_type(evt_type), .evt_syndrome(evt_syndrome), .evt_bitpos(evt_bitpos),
    .data_err_cnt(data_err_cnt), .parity_err_cnt(parity_err_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected event list of a check is derived by asking which
  // single flipped bit of the 7-bit codeword explains the syndrome.
  typedef struct { int blk; int typ; int syn; int pos; } mevt_t;

  mevt_t      q[$];
  mevt_t      m_e;
  int         m_data, m_par, m_drop, m_t;
  bit         m_ovf, m_busy, m_done, m_pop, m_full, m_push;
  logic [7:0] m_cnt;
  logic [5:0] m_pty;

  function automatic logic [2:0] enc(input logic [3:0] d);
    return {d[0]^d[2]^d[3], d[0]^d[1]^d[3], d[0]^d[1]^d[2]};
  endfunction

  function automatic mevt_t classify(input int blk, input logic [3:0] d, input logic [2:0] p);
    mevt_t      e;
    logic [2:0] s;
    logic [3:0] f;
    s = p ^ enc(d);
    e.blk = blk; e.syn = int'(s); e.typ = 0; e.pos = 0;
    for (int j = 0; j < 3; j++)
      if (s == 3'(1 << j)) begin e.typ = 2; e.pos = j; end
    for (int b = 0; b < 4; b++) begin
      f = d;
      f[b] = ~f[b];
      if (s != 3'b000 && (enc(f) ^ enc(d)) == s) begin e.typ = 1; e.pos = b; end
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_data = 0; m_par = 0; m_drop = 0; m_ovf = 0;
      m_busy = 0; m_done = 0; m_t = 0;
    end else begin
      m_pop  = evt_ready && (q.size() != 0);
      m_full = (q.size() == DEPTH);
      m_push = 0;
      m_done = 0;
      if (m_busy) begin
        m_t++;
        if (m_t <= BLOCKS) begin
          m_e = classify(m_t - 1, m_cnt[(m_t-1)*4 +: 4], m_pty[(m_t-1)*3 +: 3]);
          m_push = (m_e.syn != 0);
        end
        if (m_t == BLOCKS) m_done = 1;
        if (m_t == BLOCKS + 1) m_busy = 0;
      end else if (check_req) begin
        m_busy = 1; m_t = 0; m_cnt = counter; m_pty = parity_stored;
      end
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        if (m_e.typ == 1 && m_data < 255) m_data++;
        if (m_e.typ == 2 && m_par < 255) m_par++;
        if (m_full && !m_pop) begin
          if (m_drop < 255) m_drop++;
          m_ovf = 1;
        end else begin
          q.push_back(m_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", chk_busy, m_busy);
    chk("done", check_done, m_done);
    chk("valid", evt_valid, q.size() != 0);
    chk("data_cnt", data_err_cnt, m_data);
    chk("par_cnt", parity_err_cnt, m_par);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overflow", overflow, m_ovf);
    if (q.size() != 0) begin
      chk("head_block", evt_block, q[0].blk);
      chk("head_type", evt_type, q[0].typ);
      chk("head_syn", evt_syndrome, q[0].syn);
      chk("head_pos", evt_bitpos, q[0].pos);
    end
  end

  // Issue one check from IDLE; poke re-requests with altered live inputs mid-scan.
  task automatic run_check(input logic [7:0] c, input logic [5:0] p, input bit poke);
    int lat;
    check_req = 1'b1; counter = c; parity_stored = p;
    @(posedge clk); #1;
    lat = 1;
    check_req = poke;
    if (poke) counter = c ^ 8'h11;
    while (!check_done && lat < 20) begin
      @(posedge clk); #1;
      check_req = 1'b0;
      lat++;
    end
    check_req = 1'b0;
    if (lat >= 20) chk("done_timeout", 0, 1);
    last_lat = lat;
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
  endtask

  typedef struct { logic [7:0] c; logic [5:0] p; } vec_t;
  vec_t vecs[$];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", chk_busy, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_head_type", evt_type, 0);

    // Clean codeword: done three cycles after the request edge, no events.
    evt_ready = 1'b1;
    run_check(8'h5A, 6'h15, 1'b0);
    chk("clean_latency", last_lat, 3);
    chk("clean_valid", evt_valid, 0);
    chk("clean_data_cnt", data_err_cnt, 0);

    // Request during the scan must be ignored and the live input change unseen.
    run_check(8'h5A, 6'h15, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_valid", evt_valid, 0);
    chk("ignored_data_cnt", data_err_cnt, 0);

    evt_ready = 1'b0;
    run_check(8'h5B, 6'h15, 1'b0);
    chk("d0_valid", evt_valid, 1);
    chk("d0_block", evt_block, 0);
    chk("d0_type", evt_type, 1);
    chk("d0_syn", evt_syndrome, 7);
    chk("d0_pos", evt_bitpos, 0);
    chk("d0_cnt", data_err_cnt, 1);
    pop_one();
    chk("d0_popped", evt_valid, 0);

    run_check(8'h5A, 6'h14, 1'b0);
    chk("p0_type", evt_type, 2);
    chk("p0_syn", evt_syndrome, 1);
    chk("p0_pos", evt_bitpos, 0);
    chk("p0_cnt", parity_err_cnt, 1);
    pop_one();

    // Remaining syndrome classes, consumer always ready.
    evt_ready = 1'b1;
    vecs = '{'{8'h5A, 6'h17}, '{8'h5A, 6'h11}, '{8'h7A, 6'h15}, '{8'h1A, 6'h15},
             '{8'hDA, 6'h15}, '{8'h5A, 6'h35}, '{8'h52, 6'h05}};
    foreach (vecs[i]) run_check(vecs[i].c, vecs[i].p, 1'b0);
    chk("tbl_drained", evt_valid, 0);

    // Two-block error: order and handshake.
    evt_ready = 1'b0;
    run_check(8'h4B, 6'h15, 1'b0);
    chk("two_first_block", evt_block, 0);
    chk("two_first_syn", evt_syndrome, 7);
    pop_one();
    chk("two_second_block", evt_block, 1);
    chk("two_second_syn", evt_syndrome, 7);
    chk("two_second_type", evt_type, 1);
    pop_one();
    chk("two_empty", evt_valid, 0);

    // Asynchronous reset in the middle of a scan.
    check_req = 1'b1; counter = 8'h4B; parity_stored = 6'h15;
    @(posedge clk); #1;
    check_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", chk_busy, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_data_cnt", data_err_cnt, 0);
    chk("mid_rst_par_cnt", parity_err_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    evt_ready = 1'b1;
    run_check(8'h5B, 6'h15, 1'b0);
    chk("post_rst_latency", last_lat, 3);
    chk("post_rst_data_cnt", data_err_cnt, 1);

    // Overflow: six events into four entries with no consumer.
    evt_ready = 1'b0;
    repeat (3) run_check(8'h4B, 6'h15, 1'b0);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_data_cnt", data_err_cnt, 7);
    chk("ovf_valid", evt_valid, 1);

    // Full FIFO with a pop on both push edges: nothing dropped.
    check_req = 1'b1;
    @(posedge clk); #1;
    check_req = 1'b0;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    chk("full_pop_done", check_done, 1);
    chk("full_pop_drop", drop_cnt, 2);
    chk("full_pop_data_cnt", data_err_cnt, 9);
    @(posedge clk); #1;

    evt_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("final_empty", evt_valid, 0);
    chk("final_ovf_sticky", overflow, 1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
